simon_round_ctrl: RTL and testbench
===================================

Name: simon_round_ctrl

Overview:
- Sequencing controller for the SIMON block-cipher core (key schedule plus round datapath).
- Sits between the packet front end and the core. The front end raises newKey/newData when a key or a data block is staged. This block acknowledges each with a one-cycle load strobe, runs key expansion and the T encryption rounds, then presents the result to the output stage with a valid/ready handshake.

Parameters:
- N, 16, word size in bits (block = 2N); informational, no datapath here.
- M, 4, key words; key expansion starts at round index M.
- T, 32, total rounds.
- Cb, 5, round-counter width; must satisfy 2^Cb >= T.

Ports:
- clk  in  1  system clock, rising edge.
- nR  in  1  asynchronous active-low reset.
- newKey  in  1  front end holds high while a new key is staged.
- newData  in  1  front end holds high while a new block is staged.
- loadKey  out  1  one-cycle strobe: latch staged key into core key regs.
- loadData  out  1  one-cycle strobe: latch staged block into core state regs.
- keyExp  out  1  high: key-schedule unit computes key[round] this cycle.
- encRound  out  1  high: core applies round[round] this cycle.
- round  out  Cb  current round index.
- keyValid  out  1  expanded key schedule present.
- outValid  out  1  ciphertext valid at core output.
- outReady  in  1  output stage accepts ciphertext.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (nR low, asynchronous): state=IDLE, round=0, keyValid=0, all strobes and outValid low. Reset asserted mid-operation aborts immediately; no partial result is ever flagged.
- States: IDLE, LOAD_KEY, KEY_EXP, LOAD_DATA, ENCRYPT, DONE. All outputs are registered or decoded from the state register only; no input-to-output combinational path.
- IDLE: round=0.
  - newKey=1 -> LOAD_KEY. Key has priority when newKey and newData are both high.
  - Else newData=1 and keyValid=1 -> LOAD_DATA.
  - newData=1 with keyValid=0 is held off; remain in IDLE.
- LOAD_KEY: loadKey=1 for exactly one cycle; keyValid cleared; round<=M; -> KEY_EXP.
- KEY_EXP: keyExp=1; round increments each cycle. When round==T-1: round<=0, keyValid<=1, -> IDLE. Duration is exactly T-M cycles.
- LOAD_DATA: loadData=1 for one cycle; round<=0; -> ENCRYPT.
- ENCRYPT: encRound=1; round increments. When round==T-1: round<=0, -> DONE. Duration is exactly T cycles.
- DONE: outValid=1 until a cycle with outReady=1, then -> IDLE.
  - outValid drops in the cycle after acceptance.
  - outReady is ignored in all other states.
- Latency: with newData sampled on edge E0 in IDLE, loadData is high E0..E1, encRound is high E1..E(T+1), and outValid rises at E(T+1). With outReady tied high, busy spans T+2 cycles.
- Key/data ordering:
  - newKey/newData arriving while busy are not lost. They are levels and are acted on when IDLE is re-entered.
  - The front end drops newX in the cycle after its loadX strobe. If newX is still high on IDLE re-entry, it is treated as a new request; this is the front end's responsibility.
- Counter: round never exceeds T-1 and never wraps. Comparisons are at Cb bits.
- No state is unreachable; any illegal state encoding -> IDLE on the next clock.

Test Plan:
- Reset, then newKey pulse-held -> loadKey high 1 cycle; keyExp high 28 cycles with round 4..31; keyValid=1 in the cycle after round=31; busy low after.
- keyValid=1, newData held -> loadData 1 cycle; encRound 32 cycles with round 0..31; outValid at E33; outReady=1 -> IDLE, outValid low next cycle.
- newData raised after reset with no key -> stays IDLE 20 cycles, no loadData. Then newKey raised -> key expansion runs first, followed by loadData.
- newKey and newData rise on the same cycle (keyValid=1) -> LOAD_KEY first; data processed only after keyValid re-set (28 cycles later).
- outReady held low 10 cycles in DONE -> outValid stays high, round=0, no new loadData even with newData=1; acceptance releases to IDLE and the pending data starts.
- nR pulsed low during ENCRYPT at round=15 -> all outputs 0 immediately, keyValid=0; after release, newData alone is not accepted.

Source files
------------

// File: rtl/simon_round_ctrl.sv
// Sequencing controller for the SIMON cipher core: key load/expansion, data load,
// T encryption rounds and a valid/ready hand-off of the ciphertext.
module simon_round_ctrl #(
   parameter int unsigned N  = 16,
   parameter int unsigned M  = 4,
   parameter int unsigned T  = 32,
   parameter int unsigned Cb = 5
) (
   input  logic          clk,
   input  logic          nR,
   input  logic          newKey,
   input  logic          newData,
   output logic          loadKey,
   output logic          loadData,
   output logic          keyExp,
   output logic          encRound,
   output logic [Cb-1:0] round,
   output logic          keyValid,
   output logic          outValid,
   input  logic          outReady,
   output logic          busy
);

   if ((1 << Cb) < T || M >= T || N == 0) begin : gen_bad_params
      $error("simon_round_ctrl: inconsistent N/M/T/Cb");
   end

   localparam logic [Cb-1:0] RoundLast = Cb'(T - 1);
   localparam logic [Cb-1:0] RoundKey  = Cb'(M);

   typedef enum logic [2:0] {
      StIdle,
      StLoadKey,
      StKeyExp,
      StLoadData,
      StEncrypt,
      StDone
   } state_e;

   state_e        state_q, state_d;
   logic [Cb-1:0] round_q, round_d;
   logic          key_valid_q, key_valid_d;
   logic          load_key_q, load_data_q, key_exp_q, enc_round_q, out_valid_q, busy_q;

   always_comb begin
      state_d     = state_q;
      round_d     = round_q;
      key_valid_d = key_valid_q;
      case (state_q)
         StIdle: begin
            round_d = '0;
            // Key wins over data; data waits until a schedule exists.
            if (newKey) begin
               state_d     = StLoadKey;
               key_valid_d = 1'b0;
            end else if (newData && key_valid_q) begin
               state_d = StLoadData;
            end
         end
         StLoadKey: begin
            key_valid_d = 1'b0;
            round_d     = RoundKey;
            state_d     = StKeyExp;
         end
         StKeyExp: begin
            if (round_q == RoundLast) begin
               round_d     = '0;
               key_valid_d = 1'b1;
               state_d     = StIdle;
            end else begin
               round_d = round_q + Cb'(1);
            end
         end
         StLoadData: begin
            round_d = '0;
            state_d = StEncrypt;
         end
         StEncrypt: begin
            if (round_q == RoundLast) begin
               round_d = '0;
               state_d = StDone;
            end else begin
               round_d = round_q + Cb'(1);
            end
         end
         StDone: begin
            round_d = '0;
            if (outReady) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d     = StIdle;
            round_d     = '0;
            key_valid_d = 1'b0;
         end
      endcase
   end

   // Output flags are registered from the next state so they track state_q exactly.
   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         state_q     <= StIdle;
         round_q     <= '0;
         key_valid_q <= 1'b0;
         load_key_q  <= 1'b0;
         load_data_q <= 1'b0;
         key_exp_q   <= 1'b0;
         enc_round_q <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_q     <= round_d;
         key_valid_q <= key_valid_d;
         load_key_q  <= (state_d == StLoadKey);
         load_data_q <= (state_d == StLoadData);
         key_exp_q   <= (state_d == StKeyExp);
         enc_round_q <= (state_d == StEncrypt);
         out_valid_q <= (state_d == StDone);
         busy_q      <= (state_d != StIdle);
      end
   end

   assign loadKey  = load_key_q;
   assign loadData = load_data_q;
   assign keyExp   = key_exp_q;
   assign encRound = enc_round_q;
   assign round    = round_q;
   assign keyValid = key_valid_q;
   assign outValid = out_valid_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Directed bench for simon_round_ctrl: a vector table for the basic key/encrypt flow
// plus hand-written sequences for hold-off, priority, back-pressure and abort.
module tb_simon_round_ctrl;

   logic       clk = 1'b0;
   logic       nR;
   logic       newKey, newData, outReady;
   logic       loadKey, loadData, keyExp, encRound, keyValid, outValid, busy;
   logic [4:0] round;

   int n_pass = 0;
   int n_chk  = 0;

   simon_round_ctrl #(.N(16), .M(4), .T(32), .Cb(5)) dut (
      .clk      (clk),
      .nR       (nR),
      .newKey   (newKey),
      .newData  (newData),
      .loadKey  (loadKey),
      .loadData (loadData),
      .keyExp   (keyExp),
      .encRound (encRound),
      .round    (round),
      .keyValid (keyValid),
      .outValid (outValid),
      .outReady (outReady),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       nk, nd, rdy;
      int         cyc;
      logic       lk, ld, ke, er, kv, ov, bsy;
      logic [4:0] rnd;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   task automatic chk_all(input string tag, input logic lk, ld, ke, er, kv, ov, bsy,
                          input logic [4:0] rnd);
      chk({tag, ".loadKey"},  int'(loadKey),  int'(lk));
      chk({tag, ".loadData"}, int'(loadData), int'(ld));
      chk({tag, ".keyExp"},   int'(keyExp),   int'(ke));
      chk({tag, ".encRound"}, int'(encRound), int'(er));
      chk({tag, ".keyValid"}, int'(keyValid), int'(kv));
      chk({tag, ".outValid"}, int'(outValid), int'(ov));
      chk({tag, ".busy"},     int'(busy),     int'(bsy));
      chk({tag, ".round"},    int'(round),    int'(rnd));
   endtask

   // Advance n rising edges, then settle 1 time unit past the last edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nR = 1'b0; newKey = 1'b0; newData = 1'b0; outReady = 1'b0;
      tick(2);
      nR = 1'b1;
      tick(1);
   endtask

   initial begin
      int n;
      //            nk  nd  rdy cyc  lk  ld  ke  er  kv  ov  bsy rnd
      vecs[0]  = '{1'b0,1'b0,1'b0, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 5'd0};
      vecs[1]  = '{1'b1,1'b0,1'b0, 1, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 5'd0};
      vecs[2]  = '{1'b0,1'b0,1'b0, 1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 5'd4};
      vecs[3]  = '{1'b0,1'b0,1'b0,27, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 5'd31};
      vecs[4]  = '{1'b0,1'b0,1'b0, 1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 5'd0};
      vecs[5]  = '{1'b0,1'b1,1'b0, 1, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 5'd0};
      vecs[6]  = '{1'b0,1'b0,1'b0, 1, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 5'd0};
      vecs[7]  = '{1'b0,1'b0,1'b0,15, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 5'd15};
      vecs[8]  = '{1'b0,1'b0,1'b0,16, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 5'd31};
      vecs[9]  = '{1'b0,1'b0,1'b0, 1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 5'd0};
      vecs[10] = '{1'b0,1'b0,1'b1, 1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 5'd0};

      do_reset();
      for (int i = 0; i < 11; i++) begin
         newKey = vecs[i].nk; newData = vecs[i].nd; outReady = vecs[i].rdy;
         tick(vecs[i].cyc);
         chk_all($sformatf("vec%0d", i), vecs[i].lk, vecs[i].ld, vecs[i].ke, vecs[i].er,
                 vecs[i].kv, vecs[i].ov, vecs[i].bsy, vecs[i].rnd);
      end
      outReady = 1'b0;

      // Data without a key is held off.
      do_reset();
      newData = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk($sformatf("nokey%0d.busy", i), int'(busy), 0);
         chk($sformatf("nokey%0d.loadData", i), int'(loadData), 0);
      end
      newKey = 1'b1;
      tick(1);
      chk("nokey.loadKey", int'(loadKey), 1);
      newKey = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (!busy) break;
         if (keyExp) n++;
      end
      chk("nokey.keyExpCycles", n, 28);
      chk("nokey.keyValid", int'(keyValid), 1);
      tick(1);
      chk("nokey.loadData", int'(loadData), 1);
      newData = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (outValid) break;
         if (encRound) n++;
      end
      chk("enc.encRoundCycles", n, 32);
      chk("enc.outValid", int'(outValid), 1);
      outReady = 1'b1;
      tick(1);
      chk("enc.accept.outValid", int'(outValid), 0);
      chk("enc.accept.busy", int'(busy), 0);
      outReady = 1'b0;

      // Key and data together: key first, data after the schedule is rebuilt.
      newKey = 1'b1; newData = 1'b1;
      tick(1);
      chk_all("prio.lk", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
      newKey = 1'b0;
      tick(1);
      chk_all("prio.ke", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
      tick(28);
      chk_all("prio.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      tick(1);
      chk_all("prio.ld", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0);
      newData = 1'b0;

      // Back-pressure in DONE with data pending.
      tick(33);
      chk("bp.enterDone", int'(outValid), 1);
      newData = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk($sformatf("bp%0d.outValid", i), int'(outValid), 1);
         chk($sformatf("bp%0d.round", i), int'(round), 0);
         chk($sformatf("bp%0d.loadData", i), int'(loadData), 0);
      end
      outReady = 1'b1;
      tick(1);
      chk_all("bp.accept", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      outReady = 1'b0;
      tick(1);
      chk("bp.pendingLoad", int'(loadData), 1);
      newData = 1'b0;

      // Asynchronous abort mid-encryption.
      tick(16);
      chk_all("abort.pre", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd15);
      #2 nR = 1'b0;
      #1;
      chk_all("abort.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
      nR = 1'b1;
      newData = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk($sformatf("abort%0d.busy", i), int'(busy), 0);
         chk($sformatf("abort%0d.loadData", i), int'(loadData), 0);
      end
      newData = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
